rv32i_core: RTL and testbench

Multi-cycle RV32I integer processor core, one instruction in flight.
- It fetches instructions and performs data loads and stores through a single shared word-wide memory port.
- It sits directly on the system `memory` block, which has a 1-cycle registered read and a synchronous write.
- The top level instantiates it as the only bus master.

---
 rtl/rv32i_core.sv | 179 +++++++++++++++++
 tb/tb_rv32i_core.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_core.sv
// rv32i_core: multi-cycle RV32I core, one instruction in flight,
// sharing one word-wide memory port for fetch, load and store.
module rv32i_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    output logic [31:0] addr,
    output logic [31:0] data_out,
    output logic        mem_ren,
    output logic        mem_wen
);
    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, LOAD_WB, HALT
    } state_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    state_t      state, state_nxt;
    logic [31:0] pc, ir, rs1_val, rs2_val;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, shamt;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu_res, sra_res, pc_inc;
    logic [31:0] next_pc, wb_val;
    logic        alt, taken, wb_en;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7],
                     ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12],
                     ir[20], ir[30:21], 1'b0};
    assign pc_inc = pc + 32'd4;

    // ir[30] selects SUB only for register ops, SRA for both forms
    assign op_b    = (opcode == OP_REG) ? rs2_val : imm_i;
    assign shamt   = op_b[4:0];
    assign alt     = ir[30] && (opcode == OP_REG || f3 == 3'b101);
    assign sra_res = $signed(rs1_val) >>> shamt;

    always_comb begin
        unique case (f3)
            3'b000: alu_res = alt ? rs1_val - op_b : rs1_val + op_b;
            3'b001: alu_res = rs1_val << shamt;
            3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(op_b)};
            3'b011: alu_res = {31'b0, rs1_val < op_b};
            3'b100: alu_res = rs1_val ^ op_b;
            3'b101: alu_res = alt ? sra_res : rs1_val >> shamt;
            3'b110: alu_res = rs1_val | op_b;
            3'b111: alu_res = rs1_val & op_b;
        endcase
    end

    always_comb begin
        unique case (f3)
            3'b000:  taken = rs1_val == rs2_val;
            3'b001:  taken = rs1_val != rs2_val;
            3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  taken = rs1_val < rs2_val;
            3'b111:  taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc_inc;
        wb_val  = alu_res;
        wb_en   = 1'b0;
        unique case (opcode)
            OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
            OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_val  = pc_inc;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                wb_en   = 1'b1;
                wb_val  = pc_inc;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BR:   if (taken) next_pc = pc + imm_b;
            OP_IMM:  wb_en = 1'b1;
            OP_REG:  wb_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: state_nxt = EXECUTE;
            EXECUTE: begin
                if (opcode == OP_LOAD)     state_nxt = LOAD_WB;
                else if (opcode == OP_SYS) state_nxt = HALT;
                else                       state_nxt = FETCH;
            end
            LOAD_WB: state_nxt = FETCH;
            default: state_nxt = HALT;
        endcase
    end

    // regs[0] is cleared on reset and never written, so x0 reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            rs1_val <= '0;
            rs2_val <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                DECODE: begin
                    ir      <= data_in;
                    rs1_val <= regs[data_in[19:15]];
                    rs2_val <= regs[data_in[24:20]];
                end
                EXECUTE: begin
                    pc <= next_pc;
                    if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
                end
                LOAD_WB: if (rd != 5'd0) regs[rd] <= data_in;
                default: ;
            endcase
        end
    end

    // outputs are gated by rst so a reset mid-store never writes
    always_comb begin
        addr     = '0;
        data_out = '0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    addr    = pc;
                    mem_ren = 1'b1;
                end
                EXECUTE: begin
                    if (opcode == OP_LOAD) begin
                        addr    = rs1_val + imm_i;
                        mem_ren = 1'b1;
                    end else if (opcode == OP_STORE) begin
                        addr     = rs1_val + imm_s;
                        data_out = rs2_val;
                        mem_wen  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: instruction-level reference model predicts every
// bus request (kind, address, data, cycle); a monitor checks them.
module tb_rv32i_core;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] LD    = 7'b0000011;
    localparam logic [6:0] ST    = 7'b0100011;
    localparam logic [6:0] IMM   = 7'b0010011;
    localparam logic [6:0] REG   = 7'b0110011;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] FENCE  = 32'h0000_000F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic [31:0] addr, data_out;
    logic        mem_ren, mem_wen;

    rv32i_core #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .addr(addr), .data_out(data_out),
        .mem_ren(mem_ren), .mem_wen(mem_wen)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (mem_wen) mem[addr[11:2]] <= data_out;
        if (mem_ren) data_in <= mem[addr[11:2]];
    end

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } ev_t;

    ev_t         expq[$];
    ev_t         e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] prog[$];
    logic [31:0] mdl [1024];
    logic [31:0] xr [32];

    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (mem_ren || mem_wen || addr != 0 || data_out != 0) begin
                bad++;
                $display("FAIL reset_outputs: ren=%0b wen=%0b addr=%h dout=%h, need all 0",
                         mem_ren, mem_wen, addr, data_out);
            end
            cyc = 0;
        end else begin
            if (mem_ren || mem_wen) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_req: ren=%0b wen=%0b addr=%h cyc=%0d, need no request",
                             mem_ren, mem_wen, addr, cyc);
                end else begin
                    e = expq.pop_front();
                    if (mem_ren != !e.wr || mem_wen != e.wr || addr != e.a
                        || data_out != e.d || cyc != e.c) begin
                        bad++;
                        $display("FAIL bus_event: got ren=%0b wen=%0b addr=%h dout=%h cyc=%0d, need ren=%0b wen=%0b addr=%h dout=%h cyc=%0d",
                                 mem_ren, mem_wen, addr, data_out, cyc,
                                 !e.wr, e.wr, e.a, e.d, e.c);
                    end
                end
            end
            cyc++;
        end
    end

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
        logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, REG};
    endfunction

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1,
        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2,
        logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], ST};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2,
        logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    function automatic logic [31:0] alu(logic [2:0] f3, logic [31:0] a,
        logic [31:0] b, bit alt);
        logic [31:0] r;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd3: r = (a < b) ? 1 : 0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic bit br_taken(logic [2:0] f3, logic [31:0] a,
        logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic setx(logic [4:0] rd, logic [31:0] v);
        if (rd != 0) xr[rd] = v;
    endtask

    // instruction-level model: one loop iteration per instruction
    task automatic run_iss();
        logic [31:0] pc, ins, npc, a, r1, r2, ii;
        int t;
        bit done;
        pc = 0;
        t = 0;
        done = 0;
        for (int i = 0; i < 32; i++) xr[i] = 0;
        for (int s = 0; s < 4000 && !done; s++) begin
            ins = mdl[pc[11:2]];
            expq.push_back('{wr: 0, a: pc, d: 0, c: t});
            r1 = xr[ins[19:15]];
            r2 = xr[ins[24:20]];
            ii = {{20{ins[31]}}, ins[31:20]};
            npc = pc + 4;
            t += 3;
            case (ins[6:0])
                LUI:   setx(ins[11:7], {ins[31:12], 12'b0});
                AUIPC: setx(ins[11:7], pc + {ins[31:12], 12'b0});
                JAL: begin
                    npc = pc + {{12{ins[31]}}, ins[19:12], ins[20],
                                ins[30:21], 1'b0};
                    setx(ins[11:7], pc + 4);
                end
                JALR: begin
                    npc = (r1 + ii) & 32'hFFFF_FFFE;
                    setx(ins[11:7], pc + 4);
                end
                BR: if (br_taken(ins[14:12], r1, r2))
                    npc = pc + {{20{ins[31]}}, ins[7], ins[30:25],
                                ins[11:8], 1'b0};
                LD: begin
                    a = r1 + ii;
                    expq.push_back('{wr: 0, a: a, d: 0, c: t - 1});
                    setx(ins[11:7], mdl[a[11:2]]);
                    t += 1;
                end
                ST: begin
                    a = r1 + {{20{ins[31]}}, ins[31:25], ins[11:7]};
                    expq.push_back('{wr: 1, a: a, d: r2, c: t - 1});
                    mdl[a[11:2]] = r2;
                end
                IMM: setx(ins[11:7], alu(ins[14:12], r1, ii,
                          ins[14:12] == 3'd5 && ins[30]));
                REG: setx(ins[11:7], alu(ins[14:12], r1, r2, ins[30]));
                SYS: done = 1;
                default: ;
            endcase
            pc = npc;
        end
    endtask

    task automatic start_prog();
        @(posedge clk);
        #1 rst = 1'b1;
        expq.delete();
        for (int i = 0; i < 1024; i++) begin
            if (i < 256) mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
            else         mem[i] = $urandom;
            mdl[i] = mem[i];
        end
        run_iss();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic finish_prog(string nm);
        for (int i = 0; i < 6000 && expq.size() != 0; i++) @(posedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d requests still pending, need 0",
                     nm, expq.size());
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (mem_ren || mem_wen) begin
                bad++;
                $display("FAIL %s_halt: ren=%0b wen=%0b, need 0 0",
                         nm, mem_ren, mem_wen);
            end
        end
    endtask

    task automatic check_word(string nm, int idx, logic [31:0] exp);
        total++;
        if (mem[idx] !== exp) begin
            bad++;
            $display("FAIL %s: got %h need %h", nm, mem[idx], exp);
        end
    endtask

    task automatic gen_random();
        logic [2:0]  f3;
        logic [4:0]  rd, r1, r2;
        logic [31:0] v, ofs;
        prog.delete();
        for (int r = 1; r < 8; r++) begin
            v = $urandom;
            prog.push_back({v[31:12], 5'(r), LUI});
            prog.push_back(enc_i($urandom, 5'(r), 3'd0, 5'(r), IMM));
        end
        for (int n = 0; n < 30; n++) begin
            f3  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            v   = $urandom;
            ofs = 32'h400 + 4 * $urandom_range(0, 255);
            case ($urandom_range(0, 8))
                0: prog.push_back(enc_r(((f3 == 0 || f3 == 5) && v[0])
                       ? 7'b0100000 : 7'b0, r2, r1, f3, rd));
                1, 2: begin
                    if (f3 == 1)      v = {27'b0, v[4:0]};
                    else if (f3 == 5) v = {20'b0, 1'b0, v[10], 5'b0, v[4:0]};
                    prog.push_back(enc_i(v, r1, f3, rd, IMM));
                end
                3: prog.push_back({v[31:12], rd, v[0] ? LUI : AUIPC});
                4: prog.push_back(enc_i(ofs, 5'd0, 3'd2, rd, LD));
                5: prog.push_back(enc_s(ofs, r2, 5'd0));
                6: prog.push_back(enc_b(32'd8, r2, r1,
                       (f3 == 2 || f3 == 3) ? 3'd0 : f3));
                7: prog.push_back(enc_j(32'd8, rd));
                default: prog.push_back(FENCE);
            endcase
        end
        for (int r = 0; r < 8; r++)
            prog.push_back(enc_s(32'h400 + 4 * r, 5'(r), 5'd0));
        prog.push_back($urandom_range(0, 1) ? EBREAK : ECALL);
    endtask

    initial begin
        repeat (3) @(posedge clk);

        prog = '{enc_i(5, 0, 0, 1, IMM), enc_i(-3, 0, 0, 2, IMM),
                 enc_r(7'h00, 2, 1, 0, 3), enc_r(7'h20, 2, 1, 0, 4),
                 enc_r(7'h20, 1, 2, 5, 5), enc_r(7'h00, 2, 1, 3, 6),
                 enc_i(9, 0, 0, 0, IMM)};
        for (int r = 0; r < 7; r++)
            prog.push_back(enc_s(32'h400 + 4 * r, 5'(r), 5'd0));
        prog.push_back(EBREAK);
        start_prog();
        finish_prog("alu");
        check_word("alu_x0", 256, 32'h0);
        check_word("alu_add", 259, 32'h2);
        check_word("alu_sub", 260, 32'h8);
        check_word("alu_sra", 261, 32'hFFFF_FFFF);
        check_word("alu_sltu", 262, 32'h1);

        prog = '{enc_i(32'h40, 0, 0, 1, IMM), enc_i(32'h7B, 0, 0, 2, IMM),
                 enc_s(8, 2, 1), enc_i(8, 1, 2, 3, LD),
                 enc_s(32'h400, 3, 0), EBREAK};
        start_prog();
        finish_prog("ldst");
        check_word("ldst_sw", 18, 32'h7B);
        check_word("ldst_lw", 256, 32'h7B);

        prog = '{enc_i(1, 0, 0, 5, IMM), FENCE, FENCE, FENCE,
                 enc_b(12, 0, 0, 0), enc_i(7, 0, 0, 6, IMM),
                 enc_i(7, 0, 0, 6, IMM), enc_b(12, 0, 0, 1),
                 enc_j(8, 1), enc_i(1, 0, 0, 7, IMM),
                 enc_s(32'h400, 1, 0), enc_b(12, 0, 5, 0),
                 enc_i(0, 0, 0, 5, IMM), enc_i(5, 1, 0, 0, JALR),
                 enc_s(32'h404, 6, 0), enc_s(32'h408, 7, 0), EBREAK};
        start_prog();
        finish_prog("branch");
        check_word("jal_link", 256, 32'h24);
        check_word("beq_skip", 257, 32'h0);
        check_word("jal_skip", 258, 32'h0);

        for (int k = 0; k < 8; k++) begin
            gen_random();
            start_prog();
            finish_prog("rand");
        end

        // reset lands on the EXECUTE cycle of the sw (cycle 8)
        prog = '{enc_i(32'h40, 0, 0, 1, IMM), enc_i(32'h7B, 0, 0, 2, IMM),
                 enc_s(8, 2, 1), EBREAK};
        start_prog();
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (mem_wen) begin
            bad++;
            $display("FAIL midrst_wen: got %0b need 0", mem_wen);
        end
        repeat (2) @(posedge clk);
        check_word("midrst_nowrite", 18, 32'h0);
        prog = '{enc_s(32'h400, 1, 0), enc_s(32'h404, 2, 0), EBREAK};
        start_prog();
        finish_prog("midrst");
        check_word("midrst_x1", 256, 32'h0);
        check_word("midrst_x2", 257, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
